// File: rtl/mem_dbus_bridge.sv
// MEM-stage data-memory bridge: turns one qualified load/store into a single
// SRAM-like bus transaction, stalls the pipeline until it completes and
// returns the raw 32-bit load word.
module mem_dbus_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter bit          MAP_KSEG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MEM_ReadMem,
  input  logic                  MEM_DMWr,
  input  logic [1:0]            MEM_StoreType,
  input  logic [2:0]            MEM_LoadType,
  input  logic [ADDR_WIDTH-1:0] MEM_ALUOut,
  input  logic [31:0]           MEM_OutB,
  input  logic                  MEM_Flush,
  input  logic                  MEM_Hold,
  output logic [31:0]           MEM_DMOut,
  output logic                  DM_Stall,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [31:0]           data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [31:0]           data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    cancel_q, cancel_d;
  logic                    req_q, req_d;
  logic                    wr_q, wr_d;
  logic [1:0]              size_q, size_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             dmout_q, dmout_d;

  logic [1:0]              acc_size;
  logic                    misalign;
  logic                    acc;
  logic                    kill;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [31:0]             wdata_rep;

  // Sign/size split is only needed in WB; the sign bit is not used here.
  logic                    unused_load_sign;
  assign unused_load_sign = MEM_LoadType[2];

  // Access qualification: size select, alignment check, flush suppression.
  always_comb begin
    acc_size = MEM_DMWr ? MEM_StoreType : MEM_LoadType[1:0];
    misalign = ((acc_size == 2'b10) && (MEM_ALUOut[1:0] != 2'b00)) ||
               ((acc_size == 2'b01) && MEM_ALUOut[0]);
    acc      = (MEM_ReadMem | MEM_DMWr) & ~MEM_Flush & ~misalign;
    kill     = cancel_q | MEM_Flush;
  end

  // Virtual-to-physical: kseg0/kseg1 drop the top three address bits.
  always_comb begin
    paddr = MEM_ALUOut;
    if (MAP_KSEG && (MEM_ALUOut[ADDR_WIDTH-1 -: 2] == 2'b10)) begin
      paddr[ADDR_WIDTH-1 -: 3] = 3'b000;
    end
  end

  // Replicate store data across byte lanes according to access size.
  always_comb begin
    unique case (acc_size)
      2'b00:   wdata_rep = {4{MEM_OutB[7:0]}};
      2'b01:   wdata_rep = {2{MEM_OutB[15:0]}};
      default: wdata_rep = MEM_OutB;
    endcase
  end

  // Transaction FSM next-state, latched request fields and load capture.
  // A flush arriving on the completing cycle is treated like a pending
  // cancel so the killed instruction never sees a DONE cycle.
  always_comb begin
    state_d  = state_q;
    cancel_d = cancel_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dmout_d  = dmout_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          wr_d     = MEM_DMWr;
          size_d   = acc_size;
          addr_d   = paddr;
          wdata_d  = wdata_rep;
          cancel_d = 1'b0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (MEM_Flush) cancel_d = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            if (kill) begin
              cancel_d = 1'b0;
              state_d  = IDLE;
            end else begin
              if (!wr_q) dmout_d = data_rdata;
              state_d = DONE;
            end
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (MEM_Flush) cancel_d = 1'b1;
        if (data_data_ok) begin
          if (kill) begin
            cancel_d = 1'b0;
            state_d  = IDLE;
          end else begin
            if (!wr_q) dmout_d = data_rdata;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!MEM_Hold || MEM_Flush) begin
          cancel_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  // State and registered bus outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dmout_q  <= '0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dmout_q  <= dmout_d;
    end
  end

  assign DM_Stall   = acc & (state_q != DONE);
  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign MEM_DMOut  = dmout_q;

endmodule

// File: tb/tb_mem_dbus_bridge.sv
// Bench for mem_dbus_bridge: vector table plus hand-written flush, hold and
// reset sequences; a bus responder with programmable delays and a request
// scoreboard checked on every cycle data_req is high.
module tb_mem_dbus_bridge;

  logic        clk;
  logic        rst;
  logic        MEM_ReadMem, MEM_DMWr, MEM_Flush, MEM_Hold;
  logic [1:0]  MEM_StoreType;
  logic [2:0]  MEM_LoadType;
  logic [31:0] MEM_ALUOut, MEM_OutB;
  logic [31:0] MEM_DMOut;
  logic        DM_Stall;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  mem_dbus_bridge #(.ADDR_WIDTH(32), .MAP_KSEG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .MEM_ReadMem(MEM_ReadMem), .MEM_DMWr(MEM_DMWr),
    .MEM_StoreType(MEM_StoreType), .MEM_LoadType(MEM_LoadType),
    .MEM_ALUOut(MEM_ALUOut), .MEM_OutB(MEM_OutB),
    .MEM_Flush(MEM_Flush), .MEM_Hold(MEM_Hold),
    .MEM_DMOut(MEM_DMOut), .DM_Stall(DM_Stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bus responder: addr_ok after addr_dly req cycles, data_ok data_dly
  // cycles after addr_ok (0 = same cycle).
  int unsigned addr_dly = 0, data_dly = 0, wcnt = 0;
  logic [31:0] rdata_cfg = '0;
  bit          phase = 1'b0;

  always begin
    @(posedge clk);
    #1;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    if (!phase && data_req) begin
      if (wcnt == addr_dly) begin
        data_addr_ok = 1'b1;
        wcnt = 0;
        if (data_dly == 0) begin
          data_data_ok = 1'b1;
          data_rdata   = rdata_cfg;
        end else begin
          phase = 1'b1;
        end
      end else begin
        wcnt++;
      end
    end else if (phase) begin
      wcnt++;
      if (wcnt == data_dly) begin
        data_data_ok = 1'b1;
        data_rdata   = rdata_cfg;
        phase        = 1'b0;
        wcnt         = 0;
      end
    end
  end

  // Request scoreboard.
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
  req_t req_q[$];

  always @(negedge clk) begin
    if (rst && data_req) begin
      chk("pending_req", req_q.size(), 1);
      if (req_q.size() > 0) begin
        chk("req_wr", data_wr, req_q[0].wr);
        chk("req_size", data_size, req_q[0].size);
        chk("req_addr", data_addr, req_q[0].addr);
        if (req_q[0].wr) chk("req_wdata", data_wdata, req_q[0].wdata);
        if (data_addr_ok) void'(req_q.pop_front());
      end
    end
  end

  typedef struct {
    logic        rd, wr;
    logic [1:0]  st;
    logic [2:0]  lt;
    logic [31:0] addr, outb;
    logic        flush;
    int unsigned adly, ddly;
    logic [31:0] rdata;
    logic        issue, e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata;
    int unsigned e_stall, e_req;
    logic [31:0] e_dmout;
  } vec_t;

  localparam int NV = 13;
  vec_t vec[NV];

  task automatic drive(input logic rd, input logic wr, input logic [1:0] st,
                       input logic [2:0] lt, input logic [31:0] a, input logic [31:0] b);
    MEM_ReadMem = rd; MEM_DMWr = wr; MEM_StoreType = st; MEM_LoadType = lt;
    MEM_ALUOut = a; MEM_OutB = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int unsigned ncyc, nreq;

  initial begin
    //        rd wr st     lt      addr          outb          fl ad dd rdata         iss ewr esz    eaddr         ewdata       stl req dmout
    vec[0]  = '{0, 1, 2'b00, 3'b000, 32'hA000_0003, 32'hFFFF_FFAB, 0, 0, 0, 32'h0,         1, 1, 2'd0, 32'h0000_0003, 32'hABAB_ABAB, 2, 1, 32'h0};
    vec[1]  = '{0, 1, 2'b01, 3'b000, 32'h0000_0102, 32'h0000_BEEF, 0, 1, 0, 32'h0,         1, 1, 2'd1, 32'h0000_0102, 32'hBEEF_BEEF, 3, 2, 32'h0};
    vec[2]  = '{0, 1, 2'b10, 3'b000, 32'hBFC0_0000, 32'h1357_9BDF, 0, 1, 1, 32'h0,         1, 1, 2'd2, 32'h1FC0_0000, 32'h1357_9BDF, 4, 2, 32'h0};
    vec[3]  = '{1, 0, 2'b00, 3'b100, 32'h0000_0007, 32'h0,         0, 0, 2, 32'hCAFE_F00D, 1, 0, 2'd0, 32'h0000_0007, 32'h0,         4, 1, 32'hCAFE_F00D};
    vec[4]  = '{1, 0, 2'b00, 3'b001, 32'h0000_0001, 32'h0,         0, 0, 0, 32'h0,         0, 0, 2'd0, 32'h0,         32'h0,         0, 0, 32'hCAFE_F00D};
    vec[5]  = '{1, 0, 2'b00, 3'b010, 32'h8000_0010, 32'h0,         1, 0, 0, 32'h0,         0, 0, 2'd0, 32'h0,         32'h0,         0, 0, 32'hCAFE_F00D};
    vec[6]  = '{1, 0, 2'b00, 3'b010, 32'h8000_0002, 32'h0,         0, 0, 0, 32'h0,         0, 0, 2'd0, 32'h0,         32'h0,         0, 0, 32'hCAFE_F00D};
    vec[7]  = '{0, 1, 2'b10, 3'b000, 32'h0000_0102, 32'h1111_1111, 0, 0, 0, 32'h0,         0, 0, 2'd0, 32'h0,         32'h0,         0, 0, 32'hCAFE_F00D};
    vec[8]  = '{1, 0, 2'b00, 3'b101, 32'h0000_0006, 32'h0,         0, 0, 1, 32'h0BAD_0000, 1, 0, 2'd1, 32'h0000_0006, 32'h0,         3, 1, 32'h0BAD_0000};
    vec[9]  = '{1, 0, 2'b00, 3'b010, 32'h0000_0040, 32'h0,         0, 3, 2, 32'h5555_AAAA, 1, 0, 2'd2, 32'h0000_0040, 32'h0,         7, 4, 32'h5555_AAAA};
    vec[10] = '{1, 0, 2'b00, 3'b010, 32'hC000_0100, 32'h0,         0, 0, 0, 32'h0F0F_0F0F, 1, 0, 2'd2, 32'hC000_0100, 32'h0,         2, 1, 32'h0F0F_0F0F};
    vec[11] = '{1, 0, 2'b00, 3'b010, 32'h8000_0010, 32'h0,         0, 0, 0, 32'h1234_5678, 1, 0, 2'd2, 32'h0000_0010, 32'h0,         2, 1, 32'h1234_5678};
    vec[12] = '{0, 1, 2'b01, 3'b000, 32'h9000_0100, 32'h1234_CAFE, 0, 2, 0, 32'h0,         1, 1, 2'd1, 32'h1000_0100, 32'hCAFE_CAFE, 4, 3, 32'h1234_5678};

    rst = 1'b0; MEM_Flush = 1'b0; MEM_Hold = 1'b0;
    drive(0, 0, 2'b00, 3'b000, 32'h0, 32'h0);
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_req", data_req, 0);
    chk("rst_wr", data_wr, 0);
    chk("rst_size", data_size, 0);
    chk("rst_addr", data_addr, 0);
    chk("rst_wdata", data_wdata, 0);
    chk("rst_dmout", MEM_DMOut, 0);
    chk("rst_stall", DM_Stall, 0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    cyc();

    for (int i = 0; i < NV; i++) begin
      addr_dly = vec[i].adly; data_dly = vec[i].ddly; rdata_cfg = vec[i].rdata;
      drive(vec[i].rd, vec[i].wr, vec[i].st, vec[i].lt, vec[i].addr, vec[i].outb);
      MEM_Flush = vec[i].flush;
      if (vec[i].issue)
        req_q.push_back('{vec[i].e_wr, vec[i].e_size, vec[i].e_addr, vec[i].e_wdata});
      @(negedge clk);
      if (!vec[i].issue) begin
        chk($sformatf("v%0d_noacc_stall", i), DM_Stall, 0);
        cyc();
        @(negedge clk);
        chk($sformatf("v%0d_noacc_req", i), data_req, 0);
        chk($sformatf("v%0d_dmout", i), MEM_DMOut, vec[i].e_dmout);
      end else begin
        ncyc = 0; nreq = 0;
        while (DM_Stall && ncyc < 40) begin
          ncyc++;
          if (data_req) nreq++;
          cyc();
          @(negedge clk);
        end
        chk($sformatf("v%0d_stall_cycles", i), ncyc, vec[i].e_stall);
        chk($sformatf("v%0d_req_cycles", i), nreq, vec[i].e_req);
        chk($sformatf("v%0d_done_req", i), data_req, 0);
        chk($sformatf("v%0d_dmout", i), MEM_DMOut, vec[i].e_dmout);
      end
      cyc();
      drive(0, 0, 2'b00, 3'b000, 32'h0, 32'h0);
      MEM_Flush = 1'b0;
      @(negedge clk);
      cyc();
    end

    // Load cancelled while waiting for data: old word kept, no DONE cycle.
    addr_dly = 0; data_dly = 3; rdata_cfg = 32'hDEAD_BEEF;
    drive(1, 0, 2'b00, 3'b010, 32'h0000_0020, 32'h0);
    req_q.push_back('{1'b0, 2'd2, 32'h0000_0020, 32'h0});
    @(negedge clk); chk("fl_stall_c0", DM_Stall, 1); cyc();
    @(negedge clk); cyc();
    MEM_Flush = 1'b1;
    @(negedge clk); chk("fl_stall_flush", DM_Stall, 0); cyc();
    MEM_Flush = 1'b0; MEM_ReadMem = 1'b0;
    @(negedge clk); chk("fl_dmout_c3", MEM_DMOut, 32'h1234_5678); chk("fl_req_c3", data_req, 0); cyc();
    @(negedge clk); chk("fl_dmout_c4", MEM_DMOut, 32'h1234_5678); cyc();
    data_dly = 0; rdata_cfg = 32'h600D_F00D;
    drive(1, 0, 2'b00, 3'b010, 32'h0000_0030, 32'h0);
    req_q.push_back('{1'b0, 2'd2, 32'h0000_0030, 32'h0});
    @(negedge clk); chk("fl_next_stall", DM_Stall, 1); chk("fl_dmout_c5", MEM_DMOut, 32'h1234_5678); cyc();
    @(negedge clk); chk("fl_next_stall_req", DM_Stall, 1); cyc();
    @(negedge clk); chk("fl_next_done", DM_Stall, 0); chk("fl_next_dmout", MEM_DMOut, 32'h600D_F00D); cyc();
    drive(0, 0, 2'b00, 3'b000, 32'h0, 32'h0);
    @(negedge clk); cyc();

    // Hold in DONE for three cycles.
    addr_dly = 0; data_dly = 0; rdata_cfg = 32'h1111_2222;
    MEM_Hold = 1'b1;
    drive(1, 0, 2'b00, 3'b010, 32'h0000_0044, 32'h0);
    req_q.push_back('{1'b0, 2'd2, 32'h0000_0044, 32'h0});
    @(negedge clk); chk("hd_stall_c0", DM_Stall, 1); cyc();
    @(negedge clk); chk("hd_stall_c1", DM_Stall, 1); cyc();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hd_stall_%0d", k), DM_Stall, 0);
      chk($sformatf("hd_req_%0d", k), data_req, 0);
      chk($sformatf("hd_dmout_%0d", k), MEM_DMOut, 32'h1111_2222);
      cyc();
    end
    MEM_Hold = 1'b0;
    drive(0, 0, 2'b00, 3'b000, 32'h0, 32'h0);
    @(negedge clk); cyc();
    @(negedge clk); chk("hd_after_req", data_req, 0); cyc();

    // Reset while waiting for data; the late data_ok must be ignored.
    addr_dly = 0; data_dly = 4; rdata_cfg = 32'h7777_7777;
    drive(1, 0, 2'b00, 3'b010, 32'h0000_0050, 32'h0);
    req_q.push_back('{1'b0, 2'd2, 32'h0000_0050, 32'h0});
    @(negedge clk); cyc();
    @(negedge clk); cyc();
    rst = 1'b0; MEM_ReadMem = 1'b0;
    @(negedge clk); cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("wr_rst_req", data_req, 0);
    chk("wr_rst_wr", data_wr, 0);
    chk("wr_rst_size", data_size, 0);
    chk("wr_rst_addr", data_addr, 0);
    chk("wr_rst_wdata", data_wdata, 0);
    chk("wr_rst_dmout", MEM_DMOut, 0);
    chk("wr_rst_stall", DM_Stall, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("wr_late_dmout_%0d", k), MEM_DMOut, 0);
      chk($sformatf("wr_late_req_%0d", k), data_req, 0);
    end

    chk("scoreboard_empty", req_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
